// File: rtl/ps2_scan_rx_pkg.sv
// Shared types, key-code constants and the Set-2 scancode translation
// used by the PS/2 receiver.
package ps2_pkg;

    localparam logic [9:0] KC_BREAK     = 10'h0F0;
    localparam logic [9:0] KC_ENTER     = 10'h0C0;
    localparam logic [1:0] KC_OTHER_MSB = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    // Letters map to 0..25 in alphabetical order; anything unrecognised is
    // tagged with KC_OTHER_MSB so the writer can ignore it.
    function automatic logic [9:0] scan2key(input logic [7:0] b);
        logic [9:0] k;
        case (b)
            8'hF0:   k = KC_BREAK;
            8'h5A:   k = KC_ENTER;
            8'h1C:   k = 10'd0;
            8'h32:   k = 10'd1;
            8'h21:   k = 10'd2;
            8'h23:   k = 10'd3;
            8'h24:   k = 10'd4;
            8'h2B:   k = 10'd5;
            8'h34:   k = 10'd6;
            8'h33:   k = 10'd7;
            8'h43:   k = 10'd8;
            8'h3B:   k = 10'd9;
            8'h42:   k = 10'd10;
            8'h4B:   k = 10'd11;
            8'h3A:   k = 10'd12;
            8'h31:   k = 10'd13;
            8'h44:   k = 10'd14;
            8'h4D:   k = 10'd15;
            8'h15:   k = 10'd16;
            8'h2D:   k = 10'd17;
            8'h1B:   k = 10'd18;
            8'h2C:   k = 10'd19;
            8'h3C:   k = 10'd20;
            8'h2A:   k = 10'd21;
            8'h1D:   k = 10'd22;
            8'h22:   k = 10'd23;
            8'h35:   k = 10'd24;
            8'h1A:   k = 10'd25;
            default: k = {KC_OTHER_MSB, b};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_scan_rx_clk_filter.sv
// Two-flop synchroniser for a raw PS/2 pin, optionally followed by a
// level filter that only accepts a change after FILTER_LEN equal samples.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8,
    parameter bit USE_FILTER = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic sync1;
    logic sync2;

    // PS/2 lines idle high, so the synchroniser resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    generate
        if (USE_FILTER) begin : g_filter
            localparam int CW = $clog2(FILTER_LEN + 1);

            logic [CW-1:0] cnt;
            logic          lvl;
            logic          fall_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt    <= '0;
                    lvl    <= 1'b1;
                    fall_r <= 1'b0;
                end else begin
                    fall_r <= 1'b0;
                    if (sync2 != lvl) begin
                        if (cnt == CW'(FILTER_LEN - 1)) begin
                            lvl    <= sync2;
                            cnt    <= '0;
                            fall_r <= lvl;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
            end

            assign level = lvl;
            assign fall  = fall_r;
        end else begin : g_sync_only
            logic prev;

            always_ff @(posedge clk) begin
                if (rst) prev <= 1'b1;
                else     prev <= sync2;
            end

            assign level = sync2;
            assign fall  = prev & ~sync2;
        end
    endgenerate

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host frame receiver: deframes 11-bit frames, checks
// start/parity/stop and emits one translated key code per accepted byte.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] key_code,
    output logic       done,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data_bit;
    logic          clk_level_unused;
    logic          data_fall_unused;
    ps2_state_t    state;
    ps2_state_t    next_state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] tout_cnt;
    logic          timed_out;
    logic          accept;
    logic          reject;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN), .USE_FILTER(1'b1)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk),
        .level (clk_level_unused),
        .fall  (fall)
    );

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN), .USE_FILTER(1'b0)) u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data),
        .level (data_bit),
        .fall  (data_fall_unused)
    );

    assign timed_out = (state != IDLE) && !fall
                       && (tout_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (timed_out) begin
            next_state = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_bit) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // A frame is good only with a high stop bit and odd parity over data+parity.
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (timed_out) begin
            reject = 1'b1;
        end else if (fall) begin
            if (state == IDLE && data_bit) reject = 1'b1;
            if (state == STOP) begin
                if (data_bit && (^{shift_reg, parity_bit})) accept = 1'b1;
                else                                         reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tout_cnt   <= '0;
            key_code   <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            done      <= accept;
            frame_err <= reject;
            if (accept) key_code <= scan2key(shift_reg);

            if (state == IDLE || fall) tout_cnt <= '0;
            else                       tout_cnt <= tout_cnt + TW'(1);

            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {data_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    PARITY:  parity_bit <= data_bit;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: drives PS/2 frames on the raw pins and
// compares done/frame_err/key_code against a table-driven translation model.
module tb_ps2_scan_rx;

    localparam int FL  = 8;
    localparam int TO  = 2000;
    localparam int HP  = 30;
    localparam int LAT = 2 + FL + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] key_code;
    logic       done;
    logic       frame_err;

    ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [9:0] done_keys[$];
    int         done_cycs[$];
    int         err_cycs[$];
    int         stop_cycs[$];
    int         overlap = 0;
    int         kc_bad = 0;
    logic [9:0] prev_key = '0;
    logic [9:0] model_key = '0;
    int         last_fall = 0;
    logic [7:0] letters[26];

    // Observe outputs shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (done) begin
            done_keys.push_back(key_code);
            done_cycs.push_back(cyc);
        end
        if (frame_err) err_cycs.push_back(cyc);
        if (done && frame_err) overlap++;
        if (!rst && !done && key_code !== prev_key) kc_bad++;
        prev_key = key_code;
    end

    function automatic logic [9:0] ref_key(input logic [7:0] b);
        if (b == 8'hF0) return 10'h0F0;
        if (b == 8'h5A) return 10'h0C0;
        for (int i = 0; i < 26; i++)
            if (letters[i] == b) return 10'(i);
        return 10'h200 | 10'(b);
    endfunction

    task automatic clear_obs();
        done_keys.delete();
        done_cycs.delete();
        err_cycs.delete();
        stop_cycs.delete();
    endtask

    task automatic ps2_bit(input logic d, input bit glitch);
        @(negedge clk);
        ps2_data = d;
        if (glitch) begin
            repeat (15) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HP - 18) @(negedge clk);
        end else begin
            repeat (HP) @(negedge clk);
        end
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ bad_par, glitch);
        ps2_bit(1'b1, glitch);
        stop_cycs.push_back(last_fall);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (key_code !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_key_code got=%h exp=000", key_code);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err);
        end
        clear_obs();
        repeat (50) @(negedge clk);
        checks++;
        if (done_keys.size() + err_cycs.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_quiet got=%0d pulses exp=0", done_keys.size() + err_cycs.size());
        end
    endtask

    task automatic test_single();
        clear_obs();
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++;
        if (done_keys.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_done_count got=%0d exp=1", done_keys.size());
        end else begin
            checks++;
            if (done_keys[0] !== 10'h000) begin
                errors++;
                $display("[TB] FAIL single_key got=%h exp=000", done_keys[0]);
            end
            checks++;
            if (done_cycs[0] - stop_cycs[0] != LAT) begin
                errors++;
                $display("[TB] FAIL single_latency got=%0d exp=%0d", done_cycs[0] - stop_cycs[0], LAT);
            end
        end
        checks++;
        if (err_cycs.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_err_count got=%0d exp=0", err_cycs.size());
        end
        model_key = 10'h000;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[3];
        logic [9:0] exp_k[3];
        seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C;
        exp_k[0] = 10'h000; exp_k[1] = 10'h0F0; exp_k[2] = 10'h000;
        clear_obs();
        for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b0, 1'b0);
        checks++;
        if (done_keys.size() != 3) begin
            errors++;
            $display("[TB] FAIL b2b_done_count got=%0d exp=3", done_keys.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (done_keys[i] !== exp_k[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_key[%0d] got=%h exp=%h", i, done_keys[i], exp_k[i]);
                end
                checks++;
                if (done_cycs[i] - stop_cycs[i] != LAT) begin
                    errors++;
                    $display("[TB] FAIL b2b_latency[%0d] got=%0d exp=%0d", i, done_cycs[i] - stop_cycs[i], LAT);
                end
            end
        end
        checks++;
        if (err_cycs.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_err_count got=%0d exp=0", err_cycs.size());
        end
        model_key = 10'h000;
    endtask

    task automatic test_enter_e0();
        clear_obs();
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        checks++;
        if (done_keys.size() != 2) begin
            errors++;
            $display("[TB] FAIL enter_e0_count got=%0d exp=2", done_keys.size());
        end else begin
            checks++;
            if (done_keys[0] !== 10'h0C0) begin
                errors++;
                $display("[TB] FAIL enter_key got=%h exp=0c0", done_keys[0]);
            end
            checks++;
            if (done_keys[1] !== 10'h2E0) begin
                errors++;
                $display("[TB] FAIL e0_key got=%h exp=2e0", done_keys[1]);
            end
        end
        model_key = 10'h2E0;
    endtask

    task automatic test_bad_parity();
        clear_obs();
        send_frame(8'h1A, 1'b1, 1'b0);
        checks++;
        if (err_cycs.size() != 1) begin
            errors++;
            $display("[TB] FAIL parity_err_count got=%0d exp=1", err_cycs.size());
        end
        checks++;
        if (done_keys.size() != 0) begin
            errors++;
            $display("[TB] FAIL parity_done_count got=%0d exp=0", done_keys.size());
        end
        checks++;
        if (key_code !== model_key) begin
            errors++;
            $display("[TB] FAIL parity_key_held got=%h exp=%h", key_code, model_key);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        b = 8'h35;
        clear_obs();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i], 1'b0);
        repeat (TO + 40) @(negedge clk);
        checks++;
        if (err_cycs.size() != 1) begin
            errors++;
            $display("[TB] FAIL timeout_err_count got=%0d exp=1", err_cycs.size());
        end else begin
            checks++;
            if (err_cycs[0] - last_fall != LAT + TO) begin
                errors++;
                $display("[TB] FAIL timeout_delay got=%0d exp=%0d", err_cycs[0] - last_fall, LAT + TO);
            end
        end
        checks++;
        if (done_keys.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeout_done_count got=%0d exp=0", done_keys.size());
        end
        clear_obs();
        send_frame(8'h35, 1'b0, 1'b0);
        checks++;
        if (done_keys.size() != 1 || done_keys[0] !== 10'd24) begin
            errors++;
            $display("[TB] FAIL timeout_recover got=%0d pulses key=%h exp=1 pulse key=018",
                     done_keys.size(), key_code);
        end
        model_key = 10'd24;
    endtask

    task automatic test_idle_noise();
        clear_obs();
        ps2_bit(1'b1, 1'b0);
        checks++;
        if (err_cycs.size() != 1 || done_keys.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_bad_start got=%0d err %0d done exp=1 err 0 done",
                     err_cycs.size(), done_keys.size());
        end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        logic [9:0] exp_k;
        for (int n = 0; n < 2; n++) begin
            b = 8'($urandom);
            exp_k = ref_key(b);
            clear_obs();
            send_frame(b, 1'b0, 1'b1);
            checks++;
            if (done_keys.size() != 1 || err_cycs.size() != 0) begin
                errors++;
                $display("[TB] FAIL glitch_pulses byte=%h got=%0d done %0d err exp=1 done 0 err",
                         b, done_keys.size(), err_cycs.size());
            end else begin
                checks++;
                if (done_keys[0] !== exp_k) begin
                    errors++;
                    $display("[TB] FAIL glitch_key byte=%h got=%h exp=%h", b, done_keys[0], exp_k);
                end
                model_key = exp_k;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'h2B;
        clear_obs();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        model_key = 10'h000;
        checks++;
        if (done_keys.size() + err_cycs.size() != 0) begin
            errors++;
            $display("[TB] FAIL rst_mid_pulses got=%0d exp=0", done_keys.size() + err_cycs.size());
        end
        checks++;
        if (key_code !== model_key) begin
            errors++;
            $display("[TB] FAIL rst_mid_key got=%h exp=%h", key_code, model_key);
        end
        clear_obs();
        send_frame(b, 1'b0, 1'b0);
        checks++;
        if (done_keys.size() != 1 || done_keys[0] !== 10'd5) begin
            errors++;
            $display("[TB] FAIL rst_mid_recover got=%0d pulses key=%h exp=1 pulse key=005",
                     done_keys.size(), key_code);
        end
        model_key = 10'd5;
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         bad;
        for (int n = 0; n < 12; n++) begin
            bad = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) b = letters[$urandom_range(0, 25)];
            else                          b = 8'($urandom);
            clear_obs();
            send_frame(b, bad, 1'b0);
            if (bad) begin
                checks++;
                if (err_cycs.size() != 1 || done_keys.size() != 0 || key_code !== model_key) begin
                    errors++;
                    $display("[TB] FAIL rand_bad[%0d] byte=%h got=%0d err %0d done key=%h exp=1 err 0 done key=%h",
                             n, b, err_cycs.size(), done_keys.size(), key_code, model_key);
                end
            end else begin
                model_key = ref_key(b);
                checks++;
                if (done_keys.size() != 1 || err_cycs.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL rand_pulses[%0d] byte=%h got=%0d done %0d err exp=1 done 0 err",
                             n, b, done_keys.size(), err_cycs.size());
                end else begin
                    checks++;
                    if (done_keys[0] !== model_key) begin
                        errors++;
                        $display("[TB] FAIL rand_key[%0d] byte=%h got=%h exp=%h", n, b, done_keys[0], model_key);
                    end
                end
            end
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("[TB] FAIL done_err_overlap got=%0d exp=0", overlap);
        end
        checks++;
        if (kc_bad != 0) begin
            errors++;
            $display("[TB] FAIL key_change_without_done got=%0d exp=0", kc_bad);
        end
    endtask

    initial begin
        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        test_reset();
        test_single();
        test_back_to_back();
        test_enter_e0();
        test_bad_parity();
        test_timeout();
        test_idle_noise();
        test_glitch();
        test_reset_midframe();
        test_random();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog got=timeout exp=bench completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
